// File: rtl/lcd_frame_scan.sv
// Frame scanner: on a rising done, reads the 8x8 image out of IRB in raster order and streams it
// to the panel over valid/ready with row/frame markers. Optional checksum: LCD_SCAN_CKSUM_EN.
module lcd_frame_scan #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          done,
  input  logic [DW-1:0] irb_q,
  output logic [AW-1:0] irb_a,
  output logic          irb_cen,
  output logic          bus_own,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          row_start,
  output logic          frame_end,
`ifdef LCD_SCAN_CKSUM_EN
  output logic [15:0]   cksum,
  output logic          cksum_valid,
`endif
  output logic          scan_busy
);

  localparam int            NPIX      = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-1:0] ROW_LEN   = AW'(IMG_W);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic          row_start;
    logic          frame_end;
    logic [DW-1:0] data;
  } entry_t;

  state_t        state, state_nxt;
  logic          done_d;
  logic [AW-1:0] rd_ptr;
  logic          inflight;
  logic [AW-1:0] inflight_addr;
  entry_t        fifo_mem [2];
  logic          wr_idx, rd_idx;
  logic [1:0]    fifo_count;
  logic [1:0]    credit_used;
  logic          start, issue, push, pop;
  entry_t        head, push_entry;

  assign head      = fifo_mem[rd_idx];
  assign pix_valid = (fifo_count != 2'd0);
  assign pix_data  = pix_valid ? head.data : '0;
  assign row_start = pix_valid & head.row_start;
  assign frame_end = pix_valid & head.frame_end;

  assign pop   = pix_valid & pix_ready;
  assign push  = inflight;
  assign start = (state == IDLE) & done & ~done_d;

  // A read claims a FIFO slot for the cycle its data lands; a pop in the same
  // cycle frees one, which is what sustains one pixel per cycle.
  assign credit_used = fifo_count + {1'b0, inflight} - {1'b0, pop};
  assign issue       = (state == SCAN) && (credit_used < 2'd2);

  assign irb_cen   = ~issue;
  assign irb_a     = issue ? rd_ptr : '0;
  assign bus_own   = (state == SCAN);
  assign scan_busy = (state != IDLE);

  assign push_entry.row_start = ((inflight_addr % ROW_LEN) == '0);
  assign push_entry.frame_end = (inflight_addr == LAST_ADDR);
  assign push_entry.data      = irb_q;

  // NOTE: combinational process assigns a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (issue && rd_ptr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (pop && head.frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      done_d        <= 1'b0;
      rd_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      wr_idx        <= 1'b0;
      rd_idx        <= 1'b0;
      fifo_count    <= 2'd0;
    end else begin
      state    <= state_nxt;
      done_d   <= done;
      inflight <= issue;
      if (start)
        rd_ptr <= '0;
      else if (issue && rd_ptr != LAST_ADDR)
        rd_ptr <= rd_ptr + 1'b1;
      if (issue) inflight_addr <= rd_ptr;
      if (push)  wr_idx <= ~wr_idx;
      if (pop)   rd_idx <= ~rd_idx;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: FIFO storage is not reset; fifo_count gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= push_entry;
  end

`ifdef LCD_SCAN_CKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cksum       <= 16'h0000;
      cksum_valid <= 1'b0;
    end else begin
      cksum_valid <= pop & head.frame_end;
      if (start)
        cksum <= 16'h0000;
      else if (pop)
        cksum <= cksum + 16'(pix_data);
    end
  end
`endif

endmodule
